// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// loads the IF/ID register, with stall, redirect and end-of-program handling.
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | fetching one word per cycle from imem_addr = pc
// HALT  | fetch stopped (null word, out-of-range pc, or misaligned redirect)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1280
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        target_aligned;
    logic        pc_out_of_range;
    logic        null_word;

    assign pc_plus4        = pc + 32'd4;
    assign target_aligned  = (redirect_target[1:0] == 2'b00);
    assign pc_out_of_range = (pc >= MEM_BYTES);
    assign null_word       = (imem_instr == 32'h0000_0000);

    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            fault          <= 1'b0;
            fetch_count    <= 32'h0;
        end else if (redirect_valid) begin
            // A redirect always squashes IF/ID, even when decode is stalled.
            if_id_valid <= 1'b0;
            if (target_aligned) begin
                pc    <= redirect_target;
                state <= RUN;
                fault <= 1'b0;
            end else begin
                state <= HALT;
                fault <= 1'b1;
            end
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (pc_out_of_range) begin
                        state       <= HALT;
                        fault       <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (null_word) begin
                        state       <= HALT;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_valid    <= 1'b1;
                        if_id_pc       <= pc;
                        if_id_instr    <= imem_instr;
                        if_id_pc_plus4 <= pc_plus4;
                        pc             <= pc_plus4;
                        fetch_count    <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule
